txt_term: RTL

- Character-stream console writer that fills the 40x24 Apple II text page; this page is what the downstream raster/char-ROM stage scans out.
- Accepts ASCII bytes over a valid/ready handshake and tracks a cursor.
- Translates cursor position to the interleaved text-page address and writes screen codes into the text RAM's single read/write port.
- Handles CR, LF, BS and FF, line wrap, full-screen hardware scroll and clear-screen.

---
 rtl/txt_term.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/txt_term.sv
`default_nettype none
// ============================================================================
//  Module   : txt_term
//  Purpose  : Character-stream console writer for the 40x24 Apple II text
//             page. Accepts ASCII bytes over a valid/ready handshake, keeps a
//             cursor, and writes screen codes into the text RAM through its
//             single read/write port. Handles CR, LF, BS, FF, line wrap,
//             full-screen hardware scroll and clear-screen.
//  Ports    : clk        in   clock
//             reset      in   asynchronous, active-low reset
//             char_d     in   8  ASCII byte
//             char_valid in   char_d valid
//             char_ready out  byte accepted this cycle if char_valid is high
//             mem_adr    out  16 text RAM address
//             mem_wd     out  8  text RAM write data
//             mem_we     out  text RAM write enable
//             mem_rd     in   8  text RAM read data (one cycle after address)
//             cur_row    out  5  cursor row 0..23
//             cur_col    out  6  cursor column 0..39
//             busy       out  high in any state other than IDLE
//  Options  : TXT_TERM_UPCASE_EN - fold lowercase a..z to A..Z before writing
//  Revision : 1.0 - initial release
// ============================================================================
module txt_term #(
    parameter logic [15:0] BASE_ADR   = 16'h0400,
    parameter logic [7:0]  BLANK_CHAR = 8'hA0,
    parameter logic [7:0]  CHAR_OR    = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_d,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_wd,
    output logic        mem_we,
    input  logic [7:0]  mem_rd,
    output logic [4:0]  cur_row,
    output logic [5:0]  cur_col,
    output logic        busy
);

    localparam logic [4:0] c_LAST_ROW = 5'd23;
    localparam logic [5:0] c_LAST_COL = 6'd39;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_PUT    = 3'd2,
        S_ADV    = 3'd3,
        S_SCR_RD = 3'd4,
        S_SCR_WR = 3'd5,
        S_FILL   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_row;     // cursor
    logic [5:0]  r_col;
    logic [4:0]  r_wr;      // work counter row (clear / scroll / fill)
    logic [5:0]  r_wc;      // work counter column
    logic [7:0]  r_char;    // byte captured at acceptance

    logic [15:0] w_adr;
    logic [7:0]  w_wd;
    logic        w_we;
    logic        w_ready;
    logic        w_accept;
    logic        w_printable;
    logic        w_wc_last;
    logic        w_wr_last;

    // Interleaved text-page address: 128 bytes per row within a group of
    // eight, 40 bytes between the three groups.
    function automatic logic [15:0] f_adr(input logic [4:0] row, input logic [5:0] col);
        logic [15:0] v_adr;
        v_adr = BASE_ADR
              + {6'b0, row[2:0], 7'b0}
              + {9'b0, row[4:3], 5'b0}
              + {11'b0, row[4:3], 3'b0}
              + {10'b0, col};
        return v_adr;
    endfunction

    function automatic logic [7:0] f_screen_code(input logic [7:0] ch);
        logic [7:0] v_ch;
        v_ch = ch;
`ifdef TXT_TERM_UPCASE_EN
        // The character ROM has no lowercase glyphs.
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            v_ch = ch & 8'hDF;
        end
`else
        v_ch = ch;
`endif
        return v_ch | CHAR_OR;
    endfunction

    assign w_printable = (char_d >= 8'h20) && (char_d <= 8'h7E);
    assign w_accept    = (r_state == S_IDLE) && char_valid;
    assign w_wc_last   = (r_wc == c_LAST_COL);
    assign w_wr_last   = (r_wr == c_LAST_ROW);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_adr       = f_adr(r_row, r_col);
        w_wd        = 8'h00;
        w_we        = 1'b0;
        w_ready     = 1'b0;

        case (r_state)
            S_CLEAR: begin
                w_adr = f_adr(r_wr, r_wc);
                w_wd  = BLANK_CHAR;
                w_we  = 1'b1;
                if (w_wr_last && w_wc_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_ready = 1'b1;
                if (char_valid) begin
                    if (w_printable) begin
                        w_state_nxt = S_PUT;
                    end else if (char_d == 8'h0D || char_d == 8'h0A) begin
                        w_state_nxt = S_ADV;
                    end else if (char_d == 8'h0C) begin
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_PUT: begin
                w_wd = f_screen_code(r_char);
                w_we = 1'b1;
                w_state_nxt = (r_col == c_LAST_COL) ? S_ADV : S_IDLE;
            end
            S_ADV: begin
                w_state_nxt = (r_row < c_LAST_ROW) ? S_IDLE : S_SCR_RD;
            end
            S_SCR_RD: begin
                w_adr       = f_adr(r_wr, r_wc);
                w_state_nxt = S_SCR_WR;
            end
            S_SCR_WR: begin
                // mem_rd now holds the cell read in the previous cycle.
                w_adr = f_adr(r_wr - 5'd1, r_wc);
                w_wd  = mem_rd;
                w_we  = 1'b1;
                w_state_nxt = (w_wr_last && w_wc_last) ? S_FILL : S_SCR_RD;
            end
            S_FILL: begin
                w_adr = f_adr(c_LAST_ROW, r_wc);
                w_wd  = BLANK_CHAR;
                w_we  = 1'b1;
                if (w_wc_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cursor, work counters and byte capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row  <= 5'd0;
            r_col  <= 6'd0;
            r_wr   <= 5'd0;
            r_wc   <= 6'd0;
            r_char <= 8'h00;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (w_wc_last) begin
                        r_wc <= 6'd0;
                        if (w_wr_last) begin
                            r_wr  <= 5'd0;
                            r_row <= 5'd0;
                            r_col <= 6'd0;
                        end else begin
                            r_wr <= r_wr + 5'd1;
                        end
                    end else begin
                        r_wc <= r_wc + 6'd1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_char <= char_d;
                        if (char_d == 8'h0D) begin
                            r_col <= 6'd0;
                        end else if (char_d == 8'h08) begin
                            if (r_col != 6'd0) begin
                                r_col <= r_col - 6'd1;
                            end else if (r_row != 5'd0) begin
                                r_row <= r_row - 5'd1;
                                r_col <= c_LAST_COL;
                            end
                        end else if (char_d == 8'h0C) begin
                            r_wr <= 5'd0;
                            r_wc <= 6'd0;
                        end
                    end
                end
                S_PUT: begin
                    r_col <= (r_col == c_LAST_COL) ? 6'd0 : r_col + 6'd1;
                end
                S_ADV: begin
                    if (r_row < c_LAST_ROW) begin
                        r_row <= r_row + 5'd1;
                    end else begin
                        // Scroll copies row r to row r-1, starting at row 1.
                        r_wr <= 5'd1;
                        r_wc <= 6'd0;
                    end
                end
                S_SCR_WR: begin
                    if (w_wc_last) begin
                        r_wc <= 6'd0;
                        if (!w_wr_last) begin
                            r_wr <= r_wr + 5'd1;
                        end
                    end else begin
                        r_wc <= r_wc + 6'd1;
                    end
                end
                S_FILL: begin
                    r_wc <= w_wc_last ? 6'd0 : r_wc + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The clear state drives a write, so the port is forced quiet while
    // reset is held.
    assign mem_adr    = w_adr;
    assign mem_wd     = reset ? w_wd : 8'h00;
    assign mem_we     = reset & w_we;
    assign char_ready = reset & w_ready;
    assign busy       = (r_state != S_IDLE);
    assign cur_row    = r_row;
    assign cur_col    = r_col;

endmodule
`default_nettype wire
